// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the core data port and memory,
// with youngest-match load forwarding and a flush/drain handshake.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_memwrite,
    input  logic          i_memread,
    input  logic [AW-1:0] i_dataadr,
    input  logic [DW-1:0] i_writedata,
    input  logic          i_flush,
    output logic          o_stall,
    output logic          o_fwd_hit,
    output logic [DW-1:0] o_fwd_data,
    output logic          o_mem_valid,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic          i_mem_ready,
    output logic [CW-1:0] o_count,
    output logic          o_flush_done
);
    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    logic [AW-1:0] r_addr [DEPTH];
    logic [DW-1:0] r_data [DEPTH];
    logic [PW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_count;
    logic [0:0]    r_state;
    logic          r_flush_done;
    logic          w_full, w_enq, w_deq, w_hit;
    logic [CW-1:0] w_count_nx;
    logic [PW-1:0] w_idx;
    logic [DW-1:0] w_fdata;

    assign w_full       = r_count == CW'(DEPTH);
    assign o_stall      = (r_state == S_DRAIN) ? (i_memwrite | i_memread) : (i_memwrite & w_full);
    assign w_enq        = i_memwrite & ~o_stall;
    assign o_mem_valid  = r_count != '0;
    assign w_deq        = o_mem_valid & i_mem_ready;
    assign w_count_nx   = r_count + CW'(w_enq) - CW'(w_deq);
    assign o_mem_addr   = o_mem_valid ? r_addr[r_rp] : '0;
    assign o_mem_wdata  = o_mem_valid ? r_data[r_rp] : '0;
    assign o_count      = r_count;
    assign o_flush_done = r_flush_done;
    assign o_fwd_hit    = i_memread & ~i_memwrite & w_hit;
    assign o_fwd_data   = o_fwd_hit ? w_fdata : '0;

    // Scan oldest to youngest so the last match found is the youngest store.
    always_comb begin
        w_hit   = 1'b0;
        w_fdata = '0;
        w_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_rp + PW'(k);
            if (CW'(k) < r_count && r_addr[w_idx][AW-1:2] == i_dataadr[AW-1:2]) begin
                w_hit   = 1'b1;
                w_fdata = r_data[w_idx];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wp         <= '0;
            r_rp         <= '0;
            r_count      <= '0;
            r_state      <= S_RUN;
            r_flush_done <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_enq) begin
                r_addr[r_wp] <= i_dataadr;
                r_data[r_wp] <= i_writedata;
                r_wp         <= r_wp + 1'b1;
            end
            if (w_deq)
                r_rp <= r_rp + 1'b1;
            r_count      <= w_count_nx;
            r_flush_done <= (r_state == S_RUN) ? (i_flush && r_count == '0) : (w_count_nx == '0);
            r_state      <= (r_state == S_RUN) ? ((i_flush && r_count != '0) ? S_DRAIN : S_RUN)
                                               : ((w_count_nx == '0) ? S_RUN : S_DRAIN);
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed stimulus with a memory-port scoreboard for store_buffer.
module tb_store_buffer;
    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    logic        clk = 0, reset = 1, memwrite = 0, memread = 0, flush = 0, mem_ready = 1;
    logic [31:0] dataadr = 0, writedata = 0;
    logic        stall, fwd_hit, mem_valid, flush_done;
    logic [31:0] fwd_data, mem_addr, mem_wdata;
    logic [2:0]  count;
    int          tests = 0, fails = 0, pulses = 0;
    exp_t        q[$];

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .i_clk(clk), .i_reset(reset), .i_memwrite(memwrite), .i_memread(memread),
        .i_dataadr(dataadr), .i_writedata(writedata), .i_flush(flush),
        .o_stall(stall), .o_fwd_hit(fwd_hit), .o_fwd_data(fwd_data),
        .o_mem_valid(mem_valid), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_ready(mem_ready), .o_count(count), .o_flush_done(flush_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input bit push);
        memwrite = 1; dataadr = a; writedata = d;
        if (push) q.push_back('{a: a, d: d});
        step;
        memwrite = 0;
    endtask

    // Monitor: every accepted memory handshake must match the oldest expected store.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset && mem_valid && mem_ready) begin
            if (q.size() == 0) chk("unexpected_mem_write", mem_addr, 32'hdead_beef);
            else begin
                e = q.pop_front();
                chk("mem_addr", mem_addr, e.a);
                chk("mem_wdata", mem_wdata, e.d);
            end
        end
    end

    initial begin
        // T1 reset
        #21;
        chk("rst_stall", stall, 0); chk("rst_fwd_hit", fwd_hit, 0); chk("rst_fwd_data", fwd_data, 0);
        chk("rst_mem_valid", mem_valid, 0); chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0); chk("rst_count", count, 0); chk("rst_flush_done", flush_done, 0);
        #1 reset = 0;
        step;
        // T2 single store
        mem_ready = 0;
        st(84, 7, 1);
        chk("t2_valid", mem_valid, 1); chk("t2_addr", mem_addr, 84);
        chk("t2_wdata", mem_wdata, 7); chk("t2_count", count, 1);
        mem_ready = 1;
        step;
        chk("t2_count_after", count, 0); chk("t2_valid_after", mem_valid, 0);
        mem_ready = 0;
        // T3 full FIFO
        st(80, 'h50, 1); st(84, 'h54, 1); st(88, 'h58, 1); st(92, 'h5c, 1);
        memwrite = 1; dataadr = 96; writedata = 'h60;
        #1;
        chk("t3_stall_full", stall, 1); chk("t3_count_full", count, 4); chk("t3_head", mem_addr, 80);
        q.push_back('{a: 96, d: 'h60});
        mem_ready = 1;
        step;
        mem_ready = 0;
        #1;
        chk("t3_stall_released", stall, 0); chk("t3_count_after_deq", count, 3);
        step;
        memwrite = 0;
        #1;
        chk("t3_count_refill", count, 4); chk("t3_head2", mem_addr, 84);
        mem_ready = 1;
        repeat (4) step;
        mem_ready = 0;
        chk("t3_drained", count, 0);
        // T4 forwarding
        st(84, 5, 1); st(84, 7, 1);
        memread = 1; dataadr = 84; #1;
        chk("t4_hit", fwd_hit, 1); chk("t4_data_youngest", fwd_data, 7);
        dataadr = 86; #1;
        chk("t4_lowbits_hit", fwd_hit, 1); chk("t4_lowbits_data", fwd_data, 7);
        dataadr = 100; #1;
        chk("t4_miss_hit", fwd_hit, 0); chk("t4_miss_data", fwd_data, 0);
        dataadr = 84; memwrite = 1; #1;
        chk("t4_write_wins", fwd_hit, 0);
        memwrite = 0; mem_ready = 1; #1;
        chk("t4_deq_fwd", fwd_data, 7);
        step;
        chk("t4_last_entry_fwd", fwd_data, 7); chk("t4_count1", count, 1);
        step;
        memread = 0; mem_ready = 0;
        chk("t4_drained", count, 0);
        // T5 flush with drain
        st(80, 1, 1); st(84, 2, 1); st(88, 3, 1);
        flush = 1;
        step;
        flush = 0;
        memwrite = 1; dataadr = 200; #1;
        chk("t5_stall_store", stall, 1);
        memwrite = 0; memread = 1; dataadr = 300; #1;
        chk("t5_stall_load", stall, 1);
        for (int i = 0; i < 10; i++) begin
            mem_ready = (i % 2 == 0);
            step;
            chk($sformatf("t5_stall_i%0d", i), stall, (i < 4) ? 1 : 0);
            if (flush_done) pulses++;
        end
        chk("t5_done_pulses", pulses, 1); chk("t5_count", count, 0);
        memread = 0; mem_ready = 0;
        flush = 1;
        step;
        flush = 0;
        chk("t5_empty_flush_done", flush_done, 1);
        step;
        chk("t5_empty_flush_done_clear", flush_done, 0);
        // T6 async reset mid-drain
        st(80, 9, 0); st(84, 9, 0); st(88, 9, 0);
        flush = 1;
        step;
        flush = 0;
        chk("t6_count_pre", count, 3);
        #2 reset = 1;
        #1;
        chk("t6_valid_async", mem_valid, 0); chk("t6_count_async", count, 0);
        #10 reset = 0;
        mem_ready = 1;
        repeat (3) step;
        chk("t6_valid_post", mem_valid, 0); chk("t6_count_post", count, 0);
        memread = 1; dataadr = 80; #1;
        chk("t6_no_stale_fwd", fwd_hit, 0); chk("t6_stall_run", stall, 0);
        memread = 0;
        chk("scoreboard_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
